// File: rtl/led_pkg.sv
// led_pkg: mode codes, sequencer FSM encoding and default frame length
package led_pkg;
    typedef enum logic [1:0] {
        MODE_LEFT  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_FILL  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_t;
    localparam logic [1:0] ST_CLEAR  = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;
    localparam int FRAME_LEN_DEF = 8;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus stability counter for the mode switches
module sw_debounce #(
    parameter int DB_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    output logic [1:0] sw_db
);
    localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
    logic [1:0] s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            sw_db <= '0;
            cnt <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            if (s2 == sw_db) cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                sw_db <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: paces the LED pattern datapath and applies debounced mode changes
// only at frame ends, each change announced by a one-cycle clr pulse.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int DB_CYCLES = 3,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   sw,
    input  logic                         pause,
    output logic [1:0]                   mode,
    output logic                         step,
    output logic                         clr,
    output logic [$clog2(FRAME_LEN)-1:0] frame_pos,
    output logic                         busy
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [1:0] state, sw_db;
    logic [CW-1:0] cnt;
    logic tick;
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .sw_db(sw_db)
    );
    assign tick = cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= ST_CLEAR;
            mode <= MODE_LEFT;
            step <= 1'b0;
            clr <= 1'b0;
            frame_pos <= '0;
            busy <= 1'b0;
            cnt <= '0;
        end else begin
            step <= 1'b0;
            clr <= 1'b0;
            busy <= (state != ST_CLEAR) && (sw_db != mode);
            if (state == ST_RUN) begin
                if (pause) state <= ST_PAUSED;
                // prescaler rests during the clr cycle so the first step lands TICK_DIV+1 later
                else if (!clr) begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick && busy && (&frame_pos)) state <= ST_CLEAR;
                    else if (tick) begin
                        step <= 1'b1;
                        frame_pos <= frame_pos + 1'b1;
                    end
                end
            end else if (state == ST_PAUSED) begin
                if (!pause) state <= ST_RUN;
            end else begin
                state <= ST_RUN;
                clr <= 1'b1;
                mode <= sw_db;
                frame_pos <= '0;
                cnt <= '0;
            end
        end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed stimulus with a pulse scoreboard for led_seq_ctrl
module tb_led_seq_ctrl;
    typedef struct {
        logic       c;
        logic [1:0] m;
        logic [2:0] fp;
        logic       b;
        int         gap;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, pause = 1'b0, busy_any = 1'b0;
    logic [1:0] sw = 2'b00, mode;
    logic step, clr, busy;
    logic [2:0] frame_pos;
    int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
    exp_t q[$];
    led_seq_ctrl #(.TICK_DIV(4), .DB_CYCLES(3), .FRAME_LEN(8)) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .pause(pause),
        .mode(mode),
        .step(step),
        .clr(clr),
        .frame_pos(frame_pos),
        .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (rst) begin : monitor
            exp_t e;
            if (busy) busy_any = 1'b1;
            checks++;
            if (step && clr) begin
                errors++;
                $display("FAIL overlap cyc=%0d step=%b clr=%b required not both high", cyc, step, clr);
            end
            if (step || clr) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d step=%b clr=%b fp=%0d", cyc, step, clr, frame_pos);
                end else begin
                    e = q.pop_front();
                    if (clr !== e.c || mode !== e.m || frame_pos !== e.fp || busy !== e.b ||
                        (e.gap >= 0 && cyc - last_cyc != e.gap)) begin
                        errors++;
                        $display("FAIL pulse got clr=%b mode=%b fp=%0d busy=%b gap=%0d required clr=%b mode=%b fp=%0d busy=%b gap=%0d",
                                 clr, mode, frame_pos, busy, cyc - last_cyc, e.c, e.m, e.fp, e.b, e.gap);
                    end
                end
                last_cyc = cyc;
            end
        end
    task automatic nxt(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask
    task automatic push(input logic c, input logic [1:0] m, input logic [2:0] fp, input logic b, input int gap);
        exp_t e;
        e.c = c;
        e.m = m;
        e.fp = fp;
        e.b = b;
        e.gap = gap;
        q.push_back(e);
    endtask
    task automatic steps(input logic [2:0] from, input int n, input logic [1:0] m, input logic b, input int gap0);
        for (int i = 0; i < n; i++) push(1'b0, m, 3'(from + i), b, i == 0 ? gap0 : 4);
    endtask
    task automatic drain_to(input int left, input int lim);
        int n = 0;
        while (q.size() > left && n < lim) begin
            nxt(1);
            n++;
        end
        checks++;
        if (q.size() > left) begin
            errors++;
            $display("FAIL drain pending=%0d required %0d", q.size(), left);
            q.delete();
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        #1 rst = 1'b0;
        nxt(3);
        chk("reset_state", {mode, step, clr, frame_pos, busy}, 8'h00);
        // power-up frame in LEFT mode
        push(1'b1, 2'b00, 3'd0, 1'b0, -1);
        steps(3'd1, 8, 2'b00, 1'b0, 5);
        rst = 1'b1;
        drain_to(0, 60);
        // change to RIGHT requested at frame_pos 2
        steps(3'd1, 2, 2'b00, 1'b0, 4);
        drain_to(0, 20);
        sw = 2'b01;
        steps(3'd3, 1, 2'b00, 1'b0, 4);
        steps(3'd4, 4, 2'b00, 1'b1, 4);
        push(1'b1, 2'b01, 3'd0, 1'b0, 5);
        begin
            int k = 0;
            while (!busy && k < 10) begin
                nxt(1);
                k++;
            end
            checks++;
            if (!busy || k > 6) begin
                errors++;
                $display("FAIL busy_rise got busy=%b after %0d cycles required busy=1 within 6", busy, k);
            end
        end
        chk("mode_held_while_busy", {6'd0, mode}, 8'h00);
        drain_to(0, 60);
        // two-cycle glitch must be ignored
        steps(3'd1, 1, 2'b01, 1'b0, 5);
        steps(3'd2, 3, 2'b01, 1'b0, 4);
        drain_to(3, 20);
        busy_any = 1'b0;
        sw = 2'b10;
        nxt(2);
        sw = 2'b01;
        drain_to(0, 40);
        chk("glitch_busy", {7'd0, busy_any}, 8'h00);
        // 20-cycle pause right after a step
        pause = 1'b1;
        steps(3'd5, 1, 2'b01, 1'b0, 25);
        steps(3'd6, 1, 2'b01, 1'b0, 4);
        nxt(10);
        chk("pause_fp_hold", {5'd0, frame_pos}, 8'h04);
        nxt(10);
        pause = 1'b0;
        drain_to(0, 40);
        // pause asserted exactly on the tick cycle
        steps(3'd7, 1, 2'b01, 1'b0, 10);
        steps(3'd0, 1, 2'b01, 1'b0, 4);
        nxt(3);
        pause = 1'b1;
        nxt(5);
        pause = 1'b0;
        drain_to(0, 30);
        // change debounced while paused waits for resume and frame end
        pause = 1'b1;
        sw = 2'b11;
        steps(3'd1, 1, 2'b01, 1'b1, 17);
        steps(3'd2, 6, 2'b01, 1'b1, 4);
        push(1'b1, 2'b11, 3'd0, 1'b0, 5);
        steps(3'd1, 1, 2'b11, 1'b0, 5);
        nxt(12);
        chk("paused_busy", {7'd0, busy}, 8'h01);
        chk("paused_mode", {6'd0, mode}, 8'h01);
        pause = 1'b0;
        drain_to(0, 80);
        // reset while a step pulse is high
        rst = 1'b0;
        sw = 2'b10;
        #1;
        chk("reset_mid", {mode, step, clr, frame_pos, busy}, 8'h00);
        nxt(3);
        push(1'b1, 2'b00, 3'd0, 1'b0, -1);
        steps(3'd1, 1, 2'b00, 1'b1, 5);
        steps(3'd2, 6, 2'b00, 1'b1, 4);
        push(1'b1, 2'b10, 3'd0, 1'b0, 5);
        steps(3'd1, 1, 2'b10, 1'b0, 5);
        rst = 1'b1;
        drain_to(0, 80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
